// File: rtl/inv_tree_ctrl_pkg.sv
// Shared types and helpers for the inverter-tree pulse sequencer/checker.
package inv_tree_ctrl_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned N_OUT_DEF       = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StDone
    } ctrl_state_e;

    // Adds a and b, clamping the result at 2^width-1 (width <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-bit flop-chain synchroniser with asynchronous active-low clear.
module sync_ff_chain #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/inv_tree_pulse_ctrl.sv
// Pulse-train sequencer for the inverter fanout tree input, with a synchronised
// checker that counts compare events and per-output mismatches against ~din.
module inv_tree_pulse_ctrl
    import inv_tree_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned N_OUT       = N_OUT_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_hi,
    input  logic [CNT_W-1:0] pulse_lo,
    input  logic [CNT_W-1:0] pulse_num,
    output logic             din_o,
    input  logic [N_OUT-1:0] dout_i,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] check_cnt
);

    localparam logic [CNT_W-1:0] One   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SyncW = CNT_W'(SYNC_STAGES);

    ctrl_state_e      state_q;
    logic             din_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] lo_q;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] pulses_q;
    logic [CNT_W-1:0] mismatch_q;
    logic [CNT_W-1:0] check_q;

    logic [N_OUT-1:0] sync_dout;
    logic [CNT_W-1:0] hi_eff;
    logic [CNT_W-1:0] lo_eff;
    logic [CNT_W-1:0] cmp_width;
    logic [CNT_W-1:0] mismatch_sum;
    logic [CNT_W-1:0] check_sum;
    logic [31:0]      err_bits;
    logic             cmp_en;

    sync_ff_chain #(
        .DEPTH (SYNC_STAGES),
        .WIDTH (N_OUT)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dout_i),
        .q     (sync_dout)
    );

    always_comb begin
        hi_eff    = (pulse_hi == '0) ? One : pulse_hi;
        lo_eff    = (pulse_lo == '0) ? One : pulse_lo;
        cmp_width = (state_q == StHigh) ? hi_q : lo_q;
        // Only phases longer than the synchroniser let the tree response settle in-phase.
        cmp_en    = ((state_q == StHigh) || (state_q == StLow)) && (phase_q == '0) &&
                    (cmp_width > SyncW);
        err_bits  = '0;
        // A healthy output is the inverse of din, so equality with din is a failure.
        for (int unsigned i = 0; i < N_OUT; i++) begin
            err_bits = err_bits + 32'(sync_dout[i] == din_q);
        end
        mismatch_sum = CNT_W'(sat_add(32'(mismatch_q), err_bits, CNT_W));
        check_sum    = CNT_W'(sat_add(32'(check_q), 32'd1, CNT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            din_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            phase_q    <= '0;
            pulses_q   <= '0;
            mismatch_q <= '0;
            check_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        hi_q       <= hi_eff;
                        lo_q       <= lo_eff;
                        mismatch_q <= '0;
                        check_q    <= '0;
                        if (pulse_num == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q  <= StHigh;
                            din_q    <= 1'b1;
                            busy_q   <= 1'b1;
                            phase_q  <= hi_eff - One;
                            pulses_q <= pulse_num;
                        end
                    end
                end
                StHigh: begin
                    if (abort) begin
                        state_q <= StIdle;
                        din_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (phase_q == '0) begin
                        if (cmp_en) begin
                            check_q    <= check_sum;
                            mismatch_q <= mismatch_sum;
                        end
                        state_q  <= StLow;
                        din_q    <= 1'b0;
                        phase_q  <= lo_q - One;
                        pulses_q <= pulses_q - One;
                    end else begin
                        phase_q <= phase_q - One;
                    end
                end
                StLow: begin
                    if (abort) begin
                        state_q <= StIdle;
                        din_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (phase_q == '0) begin
                        if (cmp_en) begin
                            check_q    <= check_sum;
                            mismatch_q <= mismatch_sum;
                        end
                        if (pulses_q != '0) begin
                            state_q <= StHigh;
                            din_q   <= 1'b1;
                            phase_q <= hi_q - One;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        phase_q <= phase_q - One;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    din_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign din_o        = din_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mismatch_cnt = mismatch_q;
    assign check_cnt    = check_q;

endmodule
